// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream read adapter.
package fifo_pkg;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Width of the optional completed-transfer counter.
    localparam int CNT_W = 32;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream, grouped into one bundle.
// The master side is the adapter; the slave side is the surrounding FIFO/sink.
interface fifo_rd_stream_if #(
    parameter int WordLength = 8
);
    logic                  flush_i;
    logic                  fifo_empty_i;
    logic [WordLength-1:0] fifo_data_i;
    logic                  fifo_rd_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [WordLength-1:0] m_data_o;

    modport master (
        input  flush_i,
        input  fifo_empty_i,
        input  fifo_data_i,
        input  m_ready_i,
        output fifo_rd_o,
        output m_valid_o,
        output m_data_o
    );

    modport slave (
        output flush_i,
        output fifo_empty_i,
        output fifo_data_i,
        output m_ready_i,
        input  fifo_rd_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Two-entry head/tail skid buffer with its occupancy FSM.
// A word popped from the FIFO is captured on the same edge as the pop;
// the head register always drives the output data.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int WordLength = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  pop_i,
    input  logic [WordLength-1:0] pop_data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [WordLength-1:0] data_o,
    output state_t                state_o
);

    state_t                state_q;
    state_t                state_d;
    logic [WordLength-1:0] head_q;
    logic [WordLength-1:0] tail_q;
    logic                  xfer;
    logic                  ld_head_new;
    logic                  ld_head_tail;
    logic                  ld_tail;

    // State register: reset empties the buffer immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush wins; otherwise track pops in and transfers out.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (pop_i) state_d = ST_ONE;
                ST_ONE: begin
                    if (pop_i && !xfer)      state_d = ST_TWO;
                    else if (!pop_i && xfer) state_d = ST_EMPTY;
                end
                ST_TWO:   if (xfer) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Outputs and register load enables derived from the current state.
    always_comb begin
        valid_o      = (state_q != ST_EMPTY);
        xfer         = valid_o & ready_i & ~flush_i;
        ld_head_new  = pop_i & ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & xfer));
        ld_head_tail = (state_q == ST_TWO) & xfer;
        ld_tail      = pop_i & (state_q == ST_ONE) & ~xfer;
    end

    // Head/tail data registers; tail slides into head when the head leaves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (ld_head_new) begin
                head_q <= pop_data_i;
            end else if (ld_head_tail) begin
                head_q <= tail_q;
            end
            if (ld_tail) begin
                tail_q <= pop_data_i;
            end
        end
    end

    assign data_o  = head_q;
    assign state_o = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port into a valid/ready stream.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the 32-bit
// completed-transfer counter on port words_o.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WordLength = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fifo_rd_stream_if.master      bus
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]      words_o
`endif
);

    state_t state;
    logic   pop;

    // Pop only when there is room; the decision never looks at m_ready_i,
    // so the FIFO read strobe has no combinational path from the sink.
    always_comb begin
        pop = ~bus.fifo_empty_i & ~bus.flush_i & (state != ST_TWO) & ~rst_i;
    end

    assign bus.fifo_rd_o = pop;

    fifo_rd_buf #(
        .WordLength (WordLength)
    ) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (bus.flush_i),
        .pop_i      (pop),
        .pop_data_i (bus.fifo_data_i),
        .ready_i    (bus.m_ready_i),
        .valid_o    (bus.m_valid_o),
        .data_o     (bus.m_data_o),
        .state_o    (state)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    logic             xfer;
    logic [CNT_W-1:0] cnt_q;

    // A transfer discarded by a same-cycle flush is not counted.
    always_comb begin
        xfer = bus.m_valid_o & bus.m_ready_i & ~bus.flush_i;
    end

    // Completed-transfer counter; wraps naturally, flush leaves it alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign words_o = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: a queue-based model of the
// buffered words is compared with the DUT every cycle, plus directed
// scenarios with literal expectations.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.WordLength(8)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] words;
`endif

    fifo_rd_stream #(.WordLength(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .words_o (words)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Environment FIFO: array with read pointer and write count.
    logic [7:0] mem [0:1023];
    int         rd_ptr = 0;
    int         wr_cnt = 0;
    int         pop_cnt = 0;

    assign bus.fifo_empty_i = (rd_ptr == wr_cnt);
    assign bus.fifo_data_i  = mem[rd_ptr];

    always @(posedge clk) begin
        if (bus.fifo_rd_o) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Model: ordered list of words currently held by the adapter (max 2).
    logic [7:0] exp_buf [$];
    logic [7:0] got_q [$];
    bit         m_xf;
    bit         m_pp;
    logic [7:0] m_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_buf.delete();
        end else begin
            m_xf = (exp_buf.size() > 0) && bus.m_ready_i && !bus.flush_i;
            m_pp = (rd_ptr != wr_cnt) && !bus.flush_i && (exp_buf.size() < 2);
            m_w  = mem[rd_ptr];
            if (bus.flush_i) begin
                exp_buf.delete();
            end else begin
                if (m_xf) void'(exp_buf.pop_front());
                if (m_pp) exp_buf.push_back(m_w);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    bit exp_rd;
    always @(negedge clk) begin
        exp_rd = !rst && !bus.flush_i && (rd_ptr != wr_cnt) && (exp_buf.size() < 2);
        check("fifo_rd_o", 32'(bus.fifo_rd_o), 32'(exp_rd));
        check("m_valid_o", 32'(bus.m_valid_o), 32'(exp_buf.size() > 0));
        if (exp_buf.size() > 0) check("m_data_o", 32'(bus.m_data_o), 32'(exp_buf[0]));
        if (bus.m_valid_o && bus.m_ready_i && !bus.flush_i) got_q.push_back(bus.m_data_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        mem[wr_cnt] = w;
        wr_cnt++;
    endtask

    task automatic drain();
        bus.flush_i   = 1'b0;
        bus.m_ready_i = 1'b1;
        repeat (6) tick();
    endtask

    int p0;
    int first_v;
    int run_v;
    int total_v;
    bit vs [0:19];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        bus.flush_i   = 1'b0;
        bus.m_ready_i = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(bus.m_valid_o), 32'h0);
        check("rst_data", 32'(bus.m_data_o), 32'h0);
        check("rst_rd", 32'(bus.fifo_rd_o), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Latency: pop in cycle N, valid with 0x11 in N+1
        bus.m_ready_i = 1'b1;
        load(8'h11);
        @(negedge clk);
        check("lat_rd_N", 32'(bus.fifo_rd_o), 32'h1);
        check("lat_valid_N", 32'(bus.m_valid_o), 32'h0);
        tick();
        @(negedge clk);
        check("lat_valid_N1", 32'(bus.m_valid_o), 32'h1);
        check("lat_data_N1", 32'(bus.m_data_o), 32'h11);
        drain();

        // Stall: 4 words, ready low for 5 cycles
        bus.m_ready_i = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 4; i++) load(8'(i));
        repeat (5) tick();
        @(negedge clk);
        check("stall_pops", 32'(pop_cnt - p0), 32'd2);
        check("stall_rd", 32'(bus.fifo_rd_o), 32'h0);
        check("stall_valid", 32'(bus.m_valid_o), 32'h1);
        check("stall_data", 32'(bus.m_data_o), 32'h01);
        check("model_depth", 32'(exp_buf.size()), 32'd2);
        tick();
        got_q.delete();
        bus.m_ready_i = 1'b1;
        repeat (6) tick();
        check("stall_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) check("stall_order", 32'(got_q[i]), 32'(i + 1));
        drain();

        // Throughput: 16 words with ready held high
        got_q.delete();
        for (int i = 0; i < 16; i++) load(8'(8'h40 + i));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vs[i] = bus.m_valid_o;
            tick();
        end
        first_v = -1; run_v = 0; total_v = 0;
        for (int i = 0; i < 20; i++) begin
            if (vs[i]) begin
                total_v++;
                if (first_v < 0) first_v = i;
                if (i == first_v + run_v) run_v++;
            end
        end
        check("thr_first", 32'(first_v), 32'd1);
        check("thr_run", 32'(run_v), 32'd16);
        check("thr_total", 32'(total_v), 32'd16);
        check("thr_words", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) check("thr_last", 32'(got_q[15]), 32'h4F);
        drain();

        // Flush in ST_TWO with H=0x10, T=0x20, FIFO head 0x30
        bus.m_ready_i = 1'b0;
        load(8'h10); load(8'h20); load(8'h30);
        tick(); tick();
        @(negedge clk);
        check("fl_pre_data", 32'(bus.m_data_o), 32'h10);
        check("fl_pre_rd", 32'(bus.fifo_rd_o), 32'h0);
        tick();
        bus.flush_i   = 1'b1;
        bus.m_ready_i = 1'b1;
        #1;
        check("fl_rd_during", 32'(bus.fifo_rd_o), 32'h0);
        tick();
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("fl_valid_after", 32'(bus.m_valid_o), 32'h0);
        check("fl_rd_after", 32'(bus.fifo_rd_o), 32'h1);
        tick();
        @(negedge clk);
        check("fl_next_valid", 32'(bus.m_valid_o), 32'h1);
        check("fl_next_data", 32'(bus.m_data_o), 32'h30);
        drain();

        // Reset mid-stream with H=0xA5
        bus.m_ready_i = 1'b0;
        load(8'hA5);
        tick(); tick();
        @(negedge clk);
        check("rs_pre_data", 32'(bus.m_data_o), 32'hA5);
        #2;
        load(8'hB6);
        rst = 1'b1;
        #1;
        check("rs_valid", 32'(bus.m_valid_o), 32'h0);
        check("rs_data", 32'(bus.m_data_o), 32'h0);
        check("rs_rd", 32'(bus.fifo_rd_o), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rs_rd_release", 32'(bus.fifo_rd_o), 32'h1);
        tick();
        @(negedge clk);
        check("rs_first_word", 32'(bus.m_data_o), 32'hB6);
        drain();

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter: 300 transfers after reset, then wrap from near all-ones
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.m_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) load(8'(i));
        repeat (306) tick();
        check("cnt_300", words, 32'd300);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        load(8'hE1); load(8'hE2);
        repeat (5) tick();
        check("cnt_wrap", words, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter: WordLength, default 8, data word width in bits.
REQ-002 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 Port: flush_i  input  1  synchronous discard of all buffered words.
REQ-005 Port: fifo_empty_i  input  1  FIFO read-side empty flag.
REQ-006 Port: fifo_data_i  input  WordLength  FIFO head word, valid whenever fifo_empty_i=0.
REQ-007 Port: fifo_rd_o  output  1  pop request to FIFO; head advances at the next edge.
REQ-008 Port: m_valid_o  output  1  output word valid.
REQ-009 Port: m_ready_i  input  1  downstream accepts the word.
REQ-010 Port: m_data_o  output  WordLength  output word.

Function
REQ-011 Block SHALL drain a FIFO read port into a valid/ready stream through a 2-entry register buffer (head H, tail T).
REQ-012 FSM states SHALL be ST_EMPTY (0 words), ST_ONE (H only) and ST_TWO (H and T).
REQ-013 fifo_rd_o SHALL equal ~fifo_empty_i & ~flush_i & (state != ST_TWO), with no combinational path from m_ready_i.
REQ-014 A popped word SHALL be captured on the same edge it is popped; m_valid_o SHALL rise one cycle after the pop cycle.
REQ-015 m_valid_o SHALL be 1 exactly in ST_ONE and ST_TWO; m_data_o SHALL always drive H.
REQ-016 Transfer occurs when m_valid_o & m_ready_i; on transfer T (if present) SHALL move to H.
REQ-017 Pop and transfer in the same cycle: ST_ONE stays ST_ONE with H = new word; ST_TWO pops nothing, goes to ST_ONE with H = T.
REQ-018 Pop without transfer: ST_EMPTY->ST_ONE (word into H); ST_ONE->ST_TWO (word into T).
REQ-019 Transfer without pop: ST_ONE->ST_EMPTY; ST_TWO->ST_ONE.
REQ-020 Sustained ready with a non-empty FIFO SHALL give one word per cycle after the first-word latency.
REQ-021 While m_valid_o=1 and m_ready_i=0, m_data_o SHALL hold stable; words SHALL be delivered in FIFO order with no loss or duplication.
REQ-022 flush_i=1 SHALL force ST_EMPTY at the next edge, suppress fifo_rd_o in that cycle, and discard any same-cycle transfer.

Reset
REQ-023 rst_i=1 SHALL immediately force ST_EMPTY, H=T=0, m_valid_o=0 and m_data_o=0. fifo_rd_o SHALL be 0 while rst_i=1.
REQ-024 Reset mid-transfer SHALL discard buffered words; the first pop after release SHALL occur no earlier than the first edge with rst_i=0.

Configuration
REQ-025 Macro FIFO_RD_STREAM_CNT_EN defined: add port words_o  output  32  count of completed transfers, reset to 0, wrapping 0xFFFFFFFF->0, unaffected by flush_i.
REQ-026 Macro FIFO_RD_STREAM_CNT_EN undefined: words_o port and counter logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package fifo_pkg SHALL hold the state enum type (ST_EMPTY, ST_ONE, ST_TWO) and the counter width constant (32).
REQ-028 Sub-module fifo_rd_buf SHALL implement the H/T registers and the FSM. fifo_rd_stream SHALL hold the pop logic and the optional counter.

Verification
REQ-029 Reset check: rst_i pulse mid-stream with H=0xA5 -> m_valid_o=0, m_data_o=0 immediately, fifo_rd_o=0.
REQ-030 Latency check: FIFO holds 0x11 and m_ready_i=1 -> fifo_rd_o=1 in cycle N, m_valid_o=1 with m_data_o=0x11 in N+1.
REQ-031 Stall check: FIFO holds 0x01..0x04 and m_ready_i=0 for 5 cycles -> exactly 2 pops, state ST_TWO, m_data_o=0x01 stable; release -> 0x01..0x04 in order.
REQ-032 Throughput check: 16 words with m_ready_i=1 -> 16 consecutive valid cycles, no gaps after the first.
REQ-033 Flush check: flush_i in ST_TWO (H=0x10, T=0x20) -> next cycle m_valid_o=0, fifo_rd_o=0 during the flush cycle, and the next delivered word is the FIFO head 0x30.
REQ-034 Counter check (FIFO_RD_STREAM_CNT_EN defined): 300 transfers -> words_o=300; words_o preset near 0xFFFFFFFF wraps to 0.
